// File: rtl/hw_gpio_pkg.sv
// hw_gpio_pkg: shared constants for the hw_gpio_pio GPIO block.
//   - Word addresses of the Avalon-MM register map.
//   - Encodings of the EDGE_TYPE parameter.
package hw_gpio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/hw_gpio_pio_if.sv
// hw_gpio_pio_if: Avalon-MM slave bus bundle for hw_gpio_pio.
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    active-low write strobe
//   read_n     active-low read strobe
//   writedata  32-bit write data
//   readdata   32-bit read data, combinational from address
// Modports: master (bus host / testbench) and slave (the PIO).
interface hw_gpio_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output read_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  read_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/hw_gpio_edge_sync.sv
// hw_gpio_edge_sync: input synchroniser, delay flop and edge pulse generator.
//   clk          system clock
//   reset        asynchronous active-high reset
//   i_in         asynchronous external inputs
//   o_in_sync    inputs after SYNC_STAGES synchroniser flops
//   o_edge_pulse one-clock pulse per bit on the edge selected by EDGE_TYPE
module hw_gpio_edge_sync
    import hw_gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_in_sync,
    output logic [WIDTH-1:0] o_edge_pulse
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_in_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // Clearing both the chain and the delay flop means no edge can be seen
    // from stale pre-reset data once reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_in_d <= '0;
        end else begin
            r_sync[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_in_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_in_sync = r_sync[SYNC_STAGES-1];
    assign w_rise    = o_in_sync & ~r_in_d;
    assign w_fall    = ~o_in_sync & r_in_d;

    always_comb begin
        o_edge_pulse = w_rise;
        if (EDGE_TYPE == EDGE_FALL) begin
            o_edge_pulse = w_fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            o_edge_pulse = w_rise | w_fall;
        end
    end

endmodule

// File: rtl/hw_gpio_pio.sv
// hw_gpio_pio: parametrised Avalon-MM GPIO with direction, edge capture and irq.
//   clk       system clock
//   reset     asynchronous active-high reset
//   bus       Avalon-MM slave (hw_gpio_pio_if.slave), zero-wait-state reads
//   in_port   asynchronous external inputs
//   out_port  output data register
//   oe_port   per-bit output enable (direction register, 1 = output)
//   irq       registered level interrupt, |(edge_cap & irq_mask)
module hw_gpio_pio
    import hw_gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    hw_gpio_pio_if.slave     bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic             r_irq;

    logic [WIDTH-1:0] w_data_out_d;
    logic [WIDTH-1:0] w_dir_d;
    logic [WIDTH-1:0] w_irq_mask_d;
    logic [WIDTH-1:0] w_edge_cap_d;
    logic [WIDTH-1:0] w_edge_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_in_sync;
    logic [WIDTH-1:0] w_edge_pulse;
    logic             w_wr;

    hw_gpio_edge_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_edge_sync (
        .clk          (clk),
        .reset        (reset),
        .i_in         (in_port),
        .o_in_sync    (w_in_sync),
        .o_edge_pulse (w_edge_pulse)
    );

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];

    always_comb begin
        w_data_out_d = r_data_out;
        w_dir_d      = r_dir;
        w_irq_mask_d = r_irq_mask;
        w_edge_clr   = '0;
        if (w_wr) begin
            case (bus.address)
                ADDR_DATA:    w_data_out_d = w_wdata;
                ADDR_DIR:     w_dir_d      = w_wdata;
                ADDR_IRQMASK: w_irq_mask_d = w_wdata;
                ADDR_EDGE:    w_edge_clr   = w_wdata;
                ADDR_OUTSET:  w_data_out_d = r_data_out | w_wdata;
                ADDR_OUTCLR:  w_data_out_d = r_data_out & ~w_wdata;
                default:      ;
            endcase
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        w_edge_cap_d = (r_edge_cap & ~w_edge_clr) | w_edge_pulse;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= RESET_OUT;
            r_dir      <= RESET_DIR;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_data_out <= w_data_out_d;
            r_dir      <= w_dir_d;
            r_irq_mask <= w_irq_mask_d;
            r_edge_cap <= w_edge_cap_d;
            r_irq      <= |(r_edge_cap & r_irq_mask);
        end
    end

    always_comb begin
        w_rd = '0;
        case (bus.address)
            ADDR_DATA:    w_rd = (r_dir & r_data_out) | (~r_dir & w_in_sync);
            ADDR_DIR:     w_rd = r_dir;
            ADDR_IRQMASK: w_rd = r_irq_mask;
            ADDR_EDGE:    w_rd = r_edge_cap;
            default:      w_rd = '0;
        endcase
        bus.readdata = '0;
        if (bus.chipselect) begin
            bus.readdata[WIDTH-1:0] = w_rd;
        end
    end

    assign out_port = r_data_out;
    assign oe_port  = r_dir;
    assign irq      = r_irq;

    // Reads have no side effects, so read_n carries no function here.
    logic w_unused_read_n;
    assign w_unused_read_n = bus.read_n;

    if (WIDTH < 32) begin : g_wdata_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^bus.writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_hw_gpio_pio.sv
// tb_hw_gpio_pio: directed self-checking bench for hw_gpio_pio
// (WIDTH=8, RESET_OUT=A5, RESET_DIR=F0, rising edge, 2 sync stages).
// All stimulus tasks start and end on a falling clock edge.
module tb_hw_gpio_pio;
    import hw_gpio_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic [7:0] oe_port;
    logic       irq;

    int n_asserts;
    int n_fail;

    hw_gpio_pio_if bus ();

    hw_gpio_pio #(
        .WIDTH       (8),
        .RESET_OUT   (8'hA5),
        .RESET_DIR   (8'hF0),
        .EDGE_TYPE   (EDGE_RISE),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .in_port  (in_port),
        .out_port (out_port),
        .oe_port  (oe_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = addr;
        bus.writedata  = data;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'hDEAD_BEEF;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = addr;
        #1;
        data           = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        n_asserts      = 0;
        n_fail         = 0;
        reset          = 1'b1;
        in_port        = 8'h00;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.writedata  = 32'h0;

        // 1: reset values
        repeat (3) tick();
        check_eq("rst_out_port", 32'(out_port), 32'hA5);
        check_eq("rst_oe_port", 32'(oe_port), 32'hF0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        tick();
        bus_read(ADDR_DIR, rd);
        check_eq("rst_rd_dir", rd, 32'h0000_00F0);
        bus_read(ADDR_IRQMASK, rd);
        check_eq("rst_rd_mask", rd, 32'h0);

        // 2: data write, atomic set/clear
        bus_write(ADDR_DATA, 32'hFFFF_FF3C);
        check_eq("wr_data", 32'(out_port), 32'h3C);
        bus_write(ADDR_OUTSET, 32'h0000_0081);
        check_eq("outset", 32'(out_port), 32'hBD);
        bus_write(ADDR_OUTCLR, 32'h0000_000C);
        check_eq("outclr", 32'(out_port), 32'hB1);
        bus_read(ADDR_OUTSET, rd);
        check_eq("rd_outset", rd, 32'h0);
        bus_read(ADDR_OUTCLR, rd);
        check_eq("rd_outclr", rd, 32'h0);
        bus_read(3'd6, rd);
        check_eq("rd_addr6", rd, 32'h0);
        bus_write(3'd7, 32'hFFFF_FFFF);
        check_eq("wr_addr7_ign", 32'(out_port), 32'hB1);
        // chipselect low: readdata is 0
        bus.address = ADDR_DIR;
        #1;
        check_eq("rd_no_cs", bus.readdata, 32'h0);
        bus_read(ADDR_DATA, rd);
        check_eq("rd_data_mix1", rd, 32'h0000_00B0);

        // 3: mixed direction read-back
        tick();
        bus_write(ADDR_DIR, 32'h0000_000F);
        check_eq("oe_after_dir", 32'(oe_port), 32'h0F);
        bus_write(ADDR_DATA, 32'h0000_000A);
        in_port = 8'h50;
        repeat (4) tick();
        bus_read(ADDR_DATA, rd);
        check_eq("rd_data_mix2", rd, 32'h0000_005A);
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_50", rd, 32'h0000_0050);
        tick();
        bus_write(ADDR_EDGE, 32'h0000_0050);
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_w1c", rd, 32'h0);

        // 4: edge latency and irq
        tick();
        bus_write(ADDR_IRQMASK, 32'h0000_0001);
        in_port = 8'h51;
        tick();
        tick();
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_lat2", rd, 32'h0);
        tick();
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_lat3", rd, 32'h0000_0001);
        check_eq("irq_lat3", 32'(irq), 32'h0);
        tick();
        check_eq("irq_lat4", 32'(irq), 32'h1);
        bus_write(ADDR_EDGE, 32'h0000_0001);
        check_eq("irq_clr1", 32'(irq), 32'h1);
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_clr0", rd, 32'h0);
        tick();
        check_eq("irq_clr2", 32'(irq), 32'h0);

        // 5: edge and clear in the same cycle, irq masked off
        bus_write(ADDR_IRQMASK, 32'h0);
        in_port = 8'h55;
        tick();
        tick();
        bus_write(ADDR_EDGE, 32'h0000_0004);
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_set_wins", rd, 32'h0000_0004);
        check_eq("irq_masked", 32'(irq), 32'h0);
        tick();
        tick();
        check_eq("irq_masked2", 32'(irq), 32'h0);
        bus_write(ADDR_EDGE, 32'h0000_0004);
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_clr_b2", rd, 32'h0);

        // 6: asynchronous reset mid-operation
        tick();
        in_port = 8'h00;
        repeat (4) tick();
        bus_read(ADDR_EDGE, rd);
        check_eq("no_fall_cap", rd, 32'h0);
        tick();
        in_port = 8'hFF;
        repeat (4) tick();
        bus_read(ADDR_EDGE, rd);
        check_eq("edge_ff", rd, 32'h0000_00FF);
        tick();
        bus_write(ADDR_IRQMASK, 32'h0000_00FF);
        tick();
        check_eq("irq_pre_rst", 32'(irq), 32'h1);
        @(posedge clk);
        #2;
        reset   = 1'b1;
        in_port = 8'h00;
        #1;
        check_eq("async_irq", 32'(irq), 32'h0);
        check_eq("async_out", 32'(out_port), 32'hA5);
        check_eq("async_oe", 32'(oe_port), 32'hF0);
        bus_read(ADDR_EDGE, rd);
        check_eq("async_edge", rd, 32'h0);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        bus_read(ADDR_EDGE, rd);
        check_eq("post_rst_edge", rd, 32'h0);
        check_eq("post_rst_irq", 32'(irq), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
